dac_scheduler: RTL and testbench

Round-robin scheduler that shares the single DacSPI transmitter between the four MAX5134 channels (A–D). Each channel source posts 16-bit samples with a one-cycle request; the scheduler holds the latest sample per channel and issues one 24-bit write frame at a time, enforcing a minimum interval between frame starts. It sits between the waveform generators and DacSPI, driving DacSPI's `data_in`/`send` and observing its busy indication.

---
 rtl/dac_scheduler.sv | 172 +++++++++++++++++
 tb/tb_dac_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_scheduler.sv
// dac_scheduler: round-robin arbiter that shares one DacSPI transmitter
// between the four MAX5134 channels. Holds the latest sample per channel,
// issues one 24-bit write frame at a time and enforces a minimum spacing
// between frame starts. A DacSPI that never raises busy is flagged as a
// sticky fault and the frame is dropped.
module dac_scheduler #(
    parameter int          SEND_INTERVAL = 3624,
    parameter int          BUSY_TIMEOUT  = 15,
    parameter logic [3:0]  CMD_WRITE     = 4'b0011
) (
    input  logic        clock_in,
    input  logic        rstn,
    input  logic [3:0]  ch_req,
    input  logic [63:0] ch_data,
    output logic [3:0]  ch_ack,
    output logic [23:0] dac_data,
    output logic        dac_send,
    input  logic        dac_busy,
    output logic [1:0]  grant_ch,
    output logic        sched_busy,
    output logic        dac_fault
);

    localparam int CNT_W = $clog2(SEND_INTERVAL + 1);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] INTERVAL_MAX = CNT_W'(SEND_INTERVAL);
    localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        sample [4];
    logic [3:0]         pending;
    logic [CNT_W-1:0]   interval_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               interval_ok;
    logic               grant_found;
    logic [1:0]         grant_idx;
    logic [1:0]         cand;
    logic               launch;
    logic               tmo_hit;

    assign interval_ok = (interval_cnt == INTERVAL_MAX);
    assign sched_busy  = (state != IDLE);

    // Round-robin pick: first pending channel after the last granted one
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = grant_ch;
        cand        = grant_ch;
        for (int k = 1; k <= 4; k++) begin
            cand = grant_ch + k[1:0];
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state logic; launch marks the cycle a frame is committed
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && interval_ok) begin
                    launch     = 1'b1;
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (dac_busy) begin
                    state_next = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!dac_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample storage: latest request wins; no reset needed since pending gates use
    always_ff @(posedge clock_in) begin
        for (int i = 0; i < 4; i++) begin
            if (ch_req[i]) begin
                sample[i] <= ch_data[16*i +: 16];
            end
        end
    end

    // Pending flags and acks; a request on the granted channel keeps it pending
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            pending <= 4'b0000;
            ch_ack  <= 4'b0000;
        end else begin
            ch_ack <= ch_req;
            for (int i = 0; i < 4; i++) begin
                if (ch_req[i]) begin
                    pending[i] <= 1'b1;
                end else if (launch && (grant_idx == 2'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Frame output register: data and channel hold between grants
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            dac_send <= 1'b0;
            dac_data <= 24'h000000;
            grant_ch <= 2'd3;
        end else begin
            dac_send <= launch;
            if (launch) begin
                dac_data <= {CMD_WRITE, 4'b0001 << grant_idx, sample[grant_idx]};
                grant_ch <= grant_idx;
            end
        end
    end

    // Frame-start spacing counter, saturating so the first frame needs no wait
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            interval_cnt <= INTERVAL_MAX;
        end else if (launch) begin
            interval_cnt <= '0;
        end else if (!interval_ok) begin
            interval_cnt <= interval_cnt + 1'b1;
        end
    end

    // Busy-rise watchdog and sticky fault flag
    always_ff @(posedge clock_in or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt   <= '0;
            dac_fault <= 1'b0;
        end else begin
            if (launch) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                dac_fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_scheduler.sv
// Scoreboard bench for dac_scheduler: directed requests push expected acks
// and frames into queues; a negedge monitor pops and compares them.
module tb_dac_scheduler;

    localparam int SI = 3624;

    logic        clock_in = 1'b0;
    logic        rstn     = 1'b0;
    logic [3:0]  ch_req   = 4'b0000;
    logic [63:0] ch_data  = 64'h0;
    logic [3:0]  ch_ack;
    logic [23:0] dac_data;
    logic        dac_send;
    logic        dac_busy = 1'b0;
    logic [1:0]  grant_ch;
    logic        sched_busy;
    logic        dac_fault;

    dac_scheduler dut (
        .clock_in   (clock_in),
        .rstn       (rstn),
        .ch_req     (ch_req),
        .ch_data    (ch_data),
        .ch_ack     (ch_ack),
        .dac_data   (dac_data),
        .dac_send   (dac_send),
        .dac_busy   (dac_busy),
        .grant_ch   (grant_ch),
        .sched_busy (sched_busy),
        .dac_fault  (dac_fault)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_data_q [$];
    logic [1:0]  exp_ch_q   [$];
    logic [3:0]  exp_ack_q  [$];

    int  last_send = 0;
    bit  have_last = 1'b0;
    int  n_sends   = 0;
    bit  spi_dead  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Simple DacSPI stand-in: busy rises 2 cycles after send, lasts 5 cycles
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        forever begin
            @(posedge clock_in);
            #1;
            if (!rstn) busy_cnt = 0;
            else if (dac_send && !spi_dead) busy_cnt = 7;
            else if (busy_cnt > 0) busy_cnt--;
            dac_busy = (busy_cnt > 0) && (busy_cnt <= 5);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT acks or starts a frame
    initial begin
        forever begin
            @(negedge clock_in);
            if (!rstn) begin
                have_last = 1'b0;
            end else begin
                if (ch_ack != 4'b0000) begin
                    if (exp_ack_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: got 0x%0h expected none", ch_ack);
                    end else begin
                        check("ack", {28'h0, ch_ack}, {28'h0, exp_ack_q.pop_front()});
                    end
                end
                if (dac_send) begin
                    n_sends++;
                    if (exp_data_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_unexpected: got 0x%0h expected none", dac_data);
                    end else begin
                        check("frame_data", {8'h0, dac_data}, {8'h0, exp_data_q.pop_front()});
                        check("frame_ch", {30'h0, grant_ch}, {30'h0, exp_ch_q.pop_front()});
                    end
                    if (have_last)
                        check("frame_spacing", {31'h0, ((cyc - last_send) >= SI + 1)}, 32'h1);
                    last_send = cyc;
                    have_last = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; leaves the request up for exactly one edge
    task automatic req(input logic [3:0] mask, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
        ch_req  = mask;
        ch_data = {d3, d2, d1, d0};
        exp_ack_q.push_back(mask);
        @(posedge clock_in);
        #1;
        ch_req = 4'b0000;
    endtask

    task automatic expect_frame(input logic [23:0] d, input logic [1:0] ch);
        exp_data_q.push_back(d);
        exp_ch_q.push_back(ch);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        rstn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_data_q.size() != 0 || sched_busy) && n < budget) begin
            @(posedge clock_in);
            #1;
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d frames outstanding expected 0", exp_data_q.size());
        end
    endtask

    task automatic wait_send(input int budget, output int at);
        int n;
        n = 0;
        @(negedge clock_in);
        while (!dac_send && n < budget) begin
            @(negedge clock_in);
            n++;
        end
        if (!dac_send) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no dac_send expected one");
        end
        at = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_send"},  {31'h0, dac_send},   32'h0);
        check({tag, "_data"},  {8'h0, dac_data},    32'h0);
        check({tag, "_ack"},   {28'h0, ch_ack},     32'h0);
        check({tag, "_grant"}, {30'h0, grant_ch},   32'h3);
        check({tag, "_sbusy"}, {31'h0, sched_busy}, 32'h0);
        check({tag, "_fault"}, {31'h0, dac_fault},  32'h0);
    endtask

    // Global watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int n0;

        @(posedge clock_in);
        #1;

        // Reset values and single-channel latency
        do_reset();
        check_reset_outputs("rst");
        expect_frame(24'h311234, 2'd0);
        req(4'b0001, 16'h1234, 16'h0, 16'h0, 16'h0);
        @(negedge clock_in);
        check("t1_ack_next", {28'h0, ch_ack}, 32'h1);
        @(negedge clock_in);
        check("t1_send_k2", {31'h0, dac_send}, 32'h1);
        check("t1_data", {8'h0, dac_data}, 32'h311234);
        check("t1_grant", {30'h0, grant_ch}, 32'h0);
        @(posedge clock_in);
        #1;
        drain(200);

        // All four at once: A,B,C,D in order, spaced by the interval
        do_reset();
        expect_frame(24'h311111, 2'd0);
        expect_frame(24'h322222, 2'd1);
        expect_frame(24'h344444, 2'd2);
        expect_frame(24'h388888, 2'd3);
        req(4'b1111, 16'h1111, 16'h2222, 16'h4444, 16'h8888);
        drain(20000);

        // Channel B overwritten while held off by the interval
        expect_frame(24'h320BBB, 2'd1);
        req(4'b0010, 16'h0, 16'h0AAA, 16'h0, 16'h0);
        repeat (3) @(posedge clock_in);
        #1;
        req(4'b0010, 16'h0, 16'h0BBB, 16'h0, 16'h0);
        drain(5000);

        // Request on C at the same edge it is granted
        do_reset();
        expect_frame(24'h340100, 2'd2);
        expect_frame(24'h340200, 2'd2);
        req(4'b0100, 16'h0, 16'h0, 16'h0100, 16'h0);
        req(4'b0100, 16'h0, 16'h0, 16'h0200, 16'h0);
        drain(5000);

        // DacSPI never starts: fault after the timeout, next channel still served
        do_reset();
        spi_dead = 1'b1;
        expect_frame(24'h315555, 2'd0);
        expect_frame(24'h326666, 2'd1);
        req(4'b0011, 16'h5555, 16'h6666, 16'h0, 16'h0);
        wait_send(50, s);
        repeat (14) @(negedge clock_in);
        check("t5_fault_before", {31'h0, dac_fault}, 32'h0);
        @(negedge clock_in);
        check("t5_fault_set", {31'h0, dac_fault}, 32'h1);
        check("t5_idle", {31'h0, sched_busy}, 32'h0);
        spi_dead = 1'b0;
        @(posedge clock_in);
        #1;
        drain(5000);
        check("t5_fault_sticky", {31'h0, dac_fault}, 32'h1);

        // Reset during WAIT_DONE with B and C still pending
        do_reset();
        expect_frame(24'h317777, 2'd0);
        req(4'b0111, 16'h7777, 16'h8888, 16'h9999, 16'h0);
        wait_send(50, s);
        repeat (4) @(negedge clock_in);
        check("t6_in_frame", {31'h0, sched_busy}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) @(posedge clock_in);
        #1;
        rstn = 1'b1;
        n0 = n_sends;
        repeat (50) @(posedge clock_in);
        #1;
        check("t6_no_frame", n_sends, n0);

        check("acks_left", exp_ack_q.size(), 0);
        check("frames_left", exp_data_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
